// File: rtl/aes128_pkg.sv
// aes128_pkg: shared FSM/round types, Rcon table and GF(2^8) helpers for the AES-128 core
package aes128_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, OUT_HI, OUT_LO} state_t;
    typedef logic [3:0] rnd_t;
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    function automatic logic [7:0] rcon_at(rnd_t i);
        return i < 4'd10 ? RCON[i] : 8'h00;
    endfunction
    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    function automatic logic [31:0] mix_col(logic [31:0] w, logic inv);
        logic [31:0] cf, r;
        cf = inv ? 32'h0e0b0d09 : 32'h02030101;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[31-8*i -: 8] = r[31-8*i -: 8] ^ gmul(w[31-8*j -: 8], cf[31-8*((j-i+4)%4) -: 8]);
        return r;
    endfunction
endpackage

// File: rtl/aes128_if.sv
// aes128_if: block/key input beats and result/key output beats of the AES-128 core
interface aes128_if;
    logic        Start;
    logic        Select;
    logic [63:0] DATA;
    logic [63:0] KEY;
    logic [63:0] Cipher_text;
    logic [63:0] KEY10;
    modport master (output Start, Select, DATA, KEY, input Cipher_text, KEY10);
    modport slave (input Start, Select, DATA, KEY, output Cipher_text, KEY10);
endinterface

// File: rtl/aes128_sbox.sv
// aes128_sbox: forward/inverse AES S-box as GF(2^8) inversion (x^254) plus the (inverse) affine map
module aes128_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);
    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction
    logic [7:0] x, x2, x3, x12, x14, x15, x240, x254;
    always_comb begin
        x = inv ? rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05 : din;
        x2 = gmul(x, x);
        x3 = gmul(x2, x);
        x12 = gmul(gmul(x3, x3), gmul(x3, x3));
        x14 = gmul(x12, x2);
        x15 = gmul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++)
            x240 = gmul(x240, x240);
        x254 = gmul(x240, x14);
        dout = inv ? x254 : x254 ^ rotl(x254, 1) ^ rotl(x254, 2) ^ rotl(x254, 3) ^ rotl(x254, 4) ^ 8'h63;
    end
endmodule

// File: rtl/aes128_core.sv
// aes128_core: iterative AES-128 encrypt/decrypt, one round per clock; AES128_RESTART_EN lets Start abort and restart a busy core
module aes128_core
    import aes128_pkg::*;
(
    input  logic     CLK,
    input  logic     reset,
    aes128_if.slave  bus
);
    state_t state_q, state_d;
    rnd_t rnd_q;
    logic dec_q, start_ok;
    logic [127:0] st_q, key_q, key_nx, sub, shf, pre, mixed, rnd_out;
    logic [63:0] ct_q, k10_q;
    logic [31:0] w3, kw, ksub, t, n0;
    logic [7:0] rc;
    genvar i, c, r;
`ifdef AES128_RESTART_EN
    assign start_ok = bus.Start;
`else
    assign start_ok = bus.Start && state_q == IDLE;
`endif
    always_ff @(posedge CLK)
        state_q <= reset ? IDLE : state_d;
    always_comb begin
        state_d = start_ok ? LOAD :
                  state_q == LOAD ? ROUND :
                  (state_q == ROUND && rnd_q == 4'd10) ? OUT_HI :
                  state_q == OUT_HI ? OUT_LO :
                  state_q == OUT_LO ? IDLE : state_q;
    end
    for (i = 0; i < 16; i++) begin : g_sb
        aes128_sbox u_sb (.din(st_q[127-8*i -: 8]), .inv(dec_q), .dout(sub[127-8*i -: 8]));
    end
    for (c = 0; c < 4; c++) begin : g_col
        for (r = 0; r < 4; r++) begin : g_row
            assign shf[127-8*(4*c+r) -: 8] = dec_q ? sub[127-8*(4*((c+4-r)%4)+r) -: 8]
                                                   : sub[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mixed[127-32*c -: 32] = rnd_q != 4'd10 ? mix_col(pre[127-32*c -: 32], dec_q) : pre[127-32*c -: 32];
    end
    for (i = 0; i < 4; i++) begin : g_ks
        aes128_sbox u_ks (.din(kw[31-8*i -: 8]), .inv(1'b0), .dout(ksub[31-8*i -: 8]));
    end
    always_comb begin
        rc = rcon_at(dec_q ? rnd_t'(4'd10 - rnd_q) : rnd_t'(rnd_q - 4'd1));
        w3 = dec_q ? key_q[31:0] ^ key_q[63:32] : key_q[31:0];
        kw = {w3[23:0], w3[31:24]};
        t = ksub ^ {rc, 24'h0};
        n0 = key_q[127:96] ^ t;
        key_nx = dec_q ? {n0, key_q[95:64] ^ key_q[127:96], key_q[63:32] ^ key_q[95:64], key_q[31:0] ^ key_q[63:32]}
                       : {n0, n0 ^ key_q[95:64], n0 ^ key_q[95:64] ^ key_q[63:32], n0 ^ key_q[95:64] ^ key_q[63:32] ^ key_q[31:0]};
        pre = dec_q ? shf ^ key_nx : shf;
    end
    assign rnd_out = dec_q ? mixed : mixed ^ key_nx;
    always_ff @(posedge CLK) begin
        if (reset) begin
            st_q <= '0;
            key_q <= '0;
            rnd_q <= '0;
            dec_q <= 1'b0;
            ct_q <= '0;
            k10_q <= '0;
        end else if (start_ok) begin
            st_q[127:64] <= bus.DATA;
            key_q[127:64] <= bus.KEY;
            dec_q <= bus.Select;
        end else if (state_q == LOAD) begin
            st_q <= {st_q[127:64], bus.DATA} ^ {key_q[127:64], bus.KEY};
            key_q[63:0] <= bus.KEY;
            rnd_q <= 4'd1;
        end else if (state_q == ROUND) begin
            st_q <= rnd_out;
            key_q <= key_nx;
            rnd_q <= rnd_q + 4'd1;
            if (rnd_q == 4'd10) begin
                ct_q <= rnd_out[127:64];
                k10_q <= key_nx[127:64];
            end
        end else if (state_q == OUT_HI) begin
            ct_q <= st_q[63:0];
            k10_q <= key_q[63:0];
        end
    end
    assign bus.Cipher_text = ct_q;
    assign bus.KEY10 = k10_q;
endmodule

// File: tb/tb_aes128_core.sv
// tb_aes128_core: directed FIPS-197 vectors with a cycle-stamped scoreboard checked by a separate monitor
module tb_aes128_core;
    logic CLK = 1'b0;
    logic reset = 1'b1;
    aes128_if bus();
    aes128_core dut (.CLK(CLK), .reset(reset), .bus(bus));
    always #5 CLK = ~CLK;
    typedef struct { int cyc; logic [63:0] ct; logic [63:0] k; string nm; } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic expect_at(int c, logic [63:0] ct, logic [63:0] k, string nm);
        exp_t e;
        e.cyc = c;
        e.ct = ct;
        e.k = k;
        e.nm = nm;
        sb.push_back(e);
    endtask
    task automatic step(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    task automatic send(logic sel, logic [127:0] d, logic [127:0] k);
        bus.Start = 1'b1;
        bus.Select = sel;
        bus.DATA = d[127:64];
        bus.KEY = k[127:64];
        step(1);
        bus.Start = 1'b0;
        bus.DATA = d[63:0];
        bus.KEY = k[63:0];
        step(1);
    endtask
    task automatic op(string nm, logic sel, logic [127:0] d, logic [127:0] k, logic [127:0] res, logic [127:0] kr);
        expect_at(cyc + 12, res[127:64], kr[127:64], {nm, "_hi"});
        expect_at(cyc + 13, res[63:0], kr[63:0], {nm, "_lo"});
        send(sel, d, k);
    endtask
    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s not checked at cycle %0d", sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                checks++;
                if (bus.Cipher_text !== sb[i].ct) begin
                    errors++;
                    $display("FAIL %s Cipher_text got %h expected %h", sb[i].nm, bus.Cipher_text, sb[i].ct);
                end
                checks++;
                if (bus.KEY10 !== sb[i].k) begin
                    errors++;
                    $display("FAIL %s KEY10 got %h expected %h", sb[i].nm, bus.KEY10, sb[i].k);
                end
                sb.delete(i);
            end
        end
    end
    initial begin
        int t;
        bus.Start = 1'b0;
        bus.Select = 1'b0;
        bus.DATA = '0;
        bus.KEY = '0;
        step(3);
        reset = 1'b0;
        expect_at(cyc, 64'h0, 64'h0, "reset");
        step(1);
        t = cyc;
        op("enc_fips", 1'b0, P1, K1, C1, R1);
        expect_at(t + 14, C1[63:0], R1[63:0], "hold14");
        expect_at(t + 20, C1[63:0], R1[63:0], "hold20");
        step(12);
        op("enc_c1", 1'b0, P2, K2, C2, R2);
        step(12);
        op("dec_fips", 1'b1, C1, R1, P1, K1);
        step(12);
        op("dec_c1", 1'b1, C2, R2, P2, K2);
        step(12);
        t = cyc;
        send(1'b0, P2, K2);
        step(3);
        reset = 1'b1;
        expect_at(t + 6, 64'h0, 64'h0, "rst_abort");
        expect_at(t + 10, 64'h0, 64'h0, "rst_idle");
        step(1);
        reset = 1'b0;
        op("after_rst", 1'b0, P1, K1, C1, R1);
        step(12);
`ifdef AES128_RESTART_EN
        send(1'b0, P1, K1);
        step(4);
        op("restart", 1'b0, P2, K2, C2, R2);
        step(18);
`else
        op("ignore", 1'b1, C2, R2, P2, K2);
        step(4);
        send(1'b0, P1, K1);
        step(12);
`endif
        for (int i = 0; i < 40 && sb.size() != 0; i++)
            step(1);
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never reached cycle %0d", sb[i].nm, sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
